apb_master_ctrl: RTL and testbench

APB requester that turns a simple valid/ready command interface into compliant APB SETUP/ACCESS cycles for the 16-entry APB RAM slave on the same bus. It returns a response (read data, error flag) through a separate valid/ready channel. The block sits directly upstream of the slave and drives `psel`, `penable`, `pwrite`, `paddr` and `pwdata`; it samples `pready`, `prdata` and `pslverr`. It handles one transfer at a time, with an optional access-phase timeout watchdog.

---
 rtl/apb_master_ctrl_if.sv | 39 +++
 rtl/apb_master_ctrl.sv | 128 ++++++++++++
 tb/tb_apb_master_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_ctrl_if.sv
// Command/response handshake and APB bus signals for apb_master_ctrl.
// The master modport is the requester's view; slave is the environment driving commands and the APB slave.
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer, answered on a response channel.
// Define APB_TIMEOUT_EN to add an ACCESS-phase watchdog that aborts after TIMEOUT wait cycles.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    apb_master_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("apb_master_ctrl: TIMEOUT must be in 1..255");
    end

    state_t            state;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       rsp_timeout_q;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt      <= 8'd0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        pwrite_q    <= bus.req_write;
                        paddr_q     <= bus.req_addr;
                        pwdata_q    <= bus.req_wdata;
                        psel_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt  <= 8'd0;
`endif
                    state     <= ACCESS;
                end
                // pslverr and prdata only mean something on the pready edge
                ACCESS: begin
                    if (bus.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
`ifdef APB_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: 16-entry RAM slave stub with programmable wait states plus a transaction-level memory model.
module tb_apb_master_ctrl;
    localparam int TO    = 16;
    localparam int BOUND = 60;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(8)) bus ();

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(TO)) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // slave stub
    logic [7:0] slv_mem [16];
    int   slv_cnt   = 0;
    int   slv_waits = 0;
    int   slv_stuck = 0;
    logic junk      = 1'b0;

    always_comb begin
        bus.pready  = bus.psel && bus.penable && (slv_stuck == 0) && (slv_cnt >= slv_waits);
        bus.pslverr = bus.pready ? (bus.paddr >= 32'd16) : junk;
        bus.prdata  = (bus.paddr < 32'd16) ? slv_mem[bus.paddr[3:0]] : 8'hEE;
    end

    always @(posedge pclk) begin
        junk <= ~junk;
        if (bus.psel && bus.penable && !bus.pready) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && bus.paddr < 32'd16)
            slv_mem[bus.paddr[3:0]] <= bus.pwdata;
    end

    // reference model: memory contents as seen by completed transfers
    logic [7:0] ref_mem [16];

    // observations from the last run_xfer
    int         o_lat, o_acc_len;
    logic [7:0] o_rdata;
    logic       o_err, o_tmo, o_setup_ok, o_stable, o_hold_ok, o_idle_ok;

    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [7:0] d,
                            input int waits, input int stuck, input int hold);
        int n;
        o_setup_ok = 0; o_stable = 1; o_hold_ok = 1; o_idle_ok = 0;
        o_lat = 0; o_acc_len = 0; o_rdata = 'x; o_err = 'x; o_tmo = 'x;
        slv_waits = waits; slv_stuck = stuck;
        @(negedge pclk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        bus.rsp_ready = (hold == 0);
        n = 0;
        while (!bus.req_ready && n < BOUND) begin @(negedge pclk); n++; end
        if (!bus.req_ready) begin
            n_errors++;
            $display("FAIL xfer_accept_bound: req_ready=%0b after %0d cycles, required 1", bus.req_ready, n);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge pclk);
        bus.req_valid = 1'b0;
        o_setup_ok = bus.psel && !bus.penable && !bus.req_ready && !bus.rsp_valid &&
                     bus.paddr == a && bus.pwrite == w && bus.pwdata == d;
        o_lat = 1;
        while (!bus.rsp_valid && o_lat < BOUND) begin
            @(negedge pclk);
            o_lat++;
            if (bus.psel && bus.penable) begin
                o_acc_len++;
                if (bus.paddr !== a || bus.pwdata !== d || bus.pwrite !== w || bus.req_ready) o_stable = 0;
            end
        end
        if (!bus.rsp_valid) begin
            n_errors++;
            $display("FAIL xfer_rsp_bound: rsp_valid=%0b after %0d cycles, required 1", bus.rsp_valid, o_lat);
            return;
        end
        o_rdata = bus.rsp_rdata; o_err = bus.rsp_err; o_tmo = bus.rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            if (!bus.rsp_valid || bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err ||
                bus.rsp_timeout !== o_tmo || bus.psel || bus.req_ready) o_hold_ok = 0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        o_idle_ok = !bus.rsp_valid && bus.req_ready && !bus.psel && !bus.penable;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        n_checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: psel/pen/pwr/rvld/rerr/rto=%b required 000000",
                     {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
        end
        n_checks++;
        if (bus.paddr !== 32'd0 || bus.pwdata !== 8'd0 || bus.rsp_rdata !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h required all 0",
                     bus.paddr, bus.pwdata, bus.rsp_rdata);
        end
        preset = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        run_xfer(1'b1, 32'd5, 8'hA5, 0, 0, 0);
        ref_mem[5] = 8'hA5;
        n_checks++;
        if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 8'h00 || !o_setup_ok || !o_idle_ok) begin
            n_errors++;
            $display("FAIL wr5: lat=%0d err=%b rdata=%h setup=%b idle=%b required 3 0 00 1 1",
                     o_lat, o_err, o_rdata, o_setup_ok, o_idle_ok);
        end
        run_xfer(1'b0, 32'd5, 8'h11, 0, 0, 0);
        n_checks++;
        if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== ref_mem[5] || !o_setup_ok || !o_idle_ok) begin
            n_errors++;
            $display("FAIL rd5: lat=%0d err=%b rdata=%h setup=%b idle=%b required 3 0 %h 1 1",
                     o_lat, o_err, o_rdata, o_setup_ok, o_idle_ok, ref_mem[5]);
        end
    endtask

    task automatic test_slverr();
        run_xfer(1'b1, 32'd20, 8'h3C, 0, 0, 0);
        n_checks++;
        if (o_err !== 1'b1 || o_tmo !== 1'b0 || o_rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL wr20_err: err=%b tmo=%b rdata=%h required 1 0 00", o_err, o_tmo, o_rdata);
        end
        run_xfer(1'b0, 32'd20, 8'h00, 1, 0, 0);
        n_checks++;
        if (o_err !== 1'b1 || o_tmo !== 1'b0 || o_rdata !== 8'hEE) begin
            n_errors++;
            $display("FAIL rd20_err: err=%b tmo=%b rdata=%h required 1 0 ee", o_err, o_tmo, o_rdata);
        end
    endtask

    task automatic test_rsp_hold();
        run_xfer(1'b0, 32'd5, 8'h00, 0, 0, 10);
        n_checks++;
        if (!o_hold_ok || o_rdata !== ref_mem[5] || !o_idle_ok) begin
            n_errors++;
            $display("FAIL rsp_hold: stable=%b rdata=%h idle=%b required 1 %h 1",
                     o_hold_ok, o_rdata, o_idle_ok, ref_mem[5]);
        end
    endtask

    task automatic test_wait_states();
        run_xfer(1'b1, 32'd9, 8'h6D, 3, 0, 0);
        ref_mem[9] = 8'h6D;
        n_checks++;
        if (o_acc_len !== 4 || o_lat !== 6 || !o_stable || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wait3: access=%0d lat=%0d stable=%b err=%b required 4 6 1 0",
                     o_acc_len, o_lat, o_stable, o_err);
        end
    endtask

    task automatic test_timeout();
`ifdef APB_TIMEOUT_EN
        run_xfer(1'b1, 32'd3, 8'h77, 0, 1, 0);
        n_checks++;
        if (o_acc_len !== TO || o_lat !== TO + 2 || o_err !== 1'b1 || o_tmo !== 1'b1 || o_rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL timeout_abort: access=%0d lat=%0d err=%b tmo=%b rdata=%h required %0d %0d 1 1 00",
                     o_acc_len, o_lat, o_err, o_tmo, o_rdata, TO, TO + 2);
        end
        run_xfer(1'b0, 32'd9, 8'h00, TO - 1, 0, 0);
        n_checks++;
        if (o_acc_len !== TO || o_err !== 1'b0 || o_tmo !== 1'b0 || o_rdata !== ref_mem[9]) begin
            n_errors++;
            $display("FAIL timeout_edge_pready: access=%0d err=%b tmo=%b rdata=%h required %0d 0 0 %h",
                     o_acc_len, o_err, o_tmo, o_rdata, TO, ref_mem[9]);
        end
`else
        run_xfer(1'b0, 32'd9, 8'h00, 20, 0, 0);
        n_checks++;
        if (o_acc_len !== 21 || o_lat !== 23 || o_err !== 1'b0 || o_tmo !== 1'b0 || o_rdata !== ref_mem[9]) begin
            n_errors++;
            $display("FAIL long_wait: access=%0d lat=%0d err=%b tmo=%b rdata=%h required 21 23 0 0 %h",
                     o_acc_len, o_lat, o_err, o_tmo, o_rdata, ref_mem[9]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        slv_waits = 5; slv_stuck = 0; bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'd7; bus.req_wdata = 8'h5A;
        @(negedge pclk);
        bus.req_valid = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (!(bus.psel && bus.penable)) begin
            n_errors++;
            $display("FAIL midrst_in_access: psel=%b penable=%b required 1 1", bus.psel, bus.penable);
        end
        preset = 1'b1;
        #1;
        n_checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: psel=%b penable=%b rsp_valid=%b required 0 0 0",
                     bus.psel, bus.penable, bus.rsp_valid);
        end
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_release: req_ready=%b rsp_valid=%b required 1 0", bus.req_ready, bus.rsp_valid);
        end
        run_xfer(1'b0, 32'd7, 8'h00, 0, 0, 0);
        n_checks++;
        if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== ref_mem[7]) begin
            n_errors++;
            $display("FAIL midrst_rd7: lat=%0d err=%b rdata=%h required 3 0 %h", o_lat, o_err, o_rdata, ref_mem[7]);
        end
    endtask

    task automatic test_random();
        logic       w;
        logic [31:0] a;
        logic [7:0] d, exp_rd;
        logic       exp_err;
        int         waits, hold;
        for (int k = 0; k < 16; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 19));
            d = 8'($urandom);
            waits = $urandom_range(0, 3);
            hold  = $urandom_range(0, 2);
            exp_err = (a >= 16);
            exp_rd  = w ? 8'h00 : (a < 16 ? ref_mem[a[3:0]] : 8'hEE);
            if (w && a < 16) ref_mem[a[3:0]] = d;
            run_xfer(w, a, d, waits, 0, hold);
            n_checks++;
            if (o_rdata !== exp_rd || o_err !== exp_err || o_tmo !== 1'b0) begin
                n_errors++;
                $display("FAIL rand%0d_rsp: w=%b a=%0d rdata=%h err=%b tmo=%b required %h %b 0",
                         k, w, a, o_rdata, o_err, o_tmo, exp_rd, exp_err);
            end
            n_checks++;
            if (o_lat !== 3 + waits || o_acc_len !== waits + 1 || !o_setup_ok || !o_stable ||
                !o_hold_ok || !o_idle_ok) begin
                n_errors++;
                $display("FAIL rand%0d_timing: lat=%0d access=%0d setup=%b stable=%b hold=%b idle=%b required %0d %0d 1 1 1 1",
                         k, o_lat, o_acc_len, o_setup_ok, o_stable, o_hold_ok, o_idle_ok, 3 + waits, waits + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        cw [4];
        logic [31:0] ca [4];
        logic [7:0]  cd [4];
        logic [7:0]  exp_rd [4];
        int acc_t [4];
        int idx = 0, nrsp = 0, t = 0, overlap = 0, psel_cyc = 0, psel_rise = 0;
        logic prev_psel = 1'b0, accepting;
        for (int i = 0; i < 4; i++) begin
            cw[i] = 1'($urandom_range(0, 1));
            ca[i] = 32'($urandom_range(0, 15));
            cd[i] = 8'($urandom);
            exp_rd[i] = cw[i] ? 8'h00 : ref_mem[ca[i][3:0]];
            if (cw[i]) ref_mem[ca[i][3:0]] = cd[i];
            acc_t[i] = -1;
        end
        slv_waits = 0; slv_stuck = 0; bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.req_valid = 1'b1; bus.req_write = cw[0]; bus.req_addr = ca[0]; bus.req_wdata = cd[0];
        while (nrsp < 4 && t < 80) begin
            if (bus.rsp_valid) begin
                n_checks++;
                if (bus.rsp_rdata !== exp_rd[nrsp] || bus.rsp_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_rsp%0d: rdata=%h err=%b required %h 0",
                             nrsp, bus.rsp_rdata, bus.rsp_err, exp_rd[nrsp]);
                end
                nrsp++;
            end
            if (bus.psel && bus.req_ready) overlap++;
            if (bus.psel) psel_cyc++;
            if (bus.psel && !prev_psel) psel_rise++;
            prev_psel = bus.psel;
            accepting = bus.req_valid && bus.req_ready;
            if (accepting) acc_t[idx] = t;
            @(negedge pclk);
            t++;
            if (accepting) begin
                idx++;
                if (idx < 4) begin
                    bus.req_write = cw[idx]; bus.req_addr = ca[idx]; bus.req_wdata = cd[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (nrsp !== 4) begin
            n_errors++;
            $display("FAIL b2b_rsp_count: got %0d required 4", nrsp);
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (acc_t[i] - acc_t[i-1] !== 4) begin
                n_errors++;
                $display("FAIL b2b_spacing%0d: got %0d required 4", i, acc_t[i] - acc_t[i-1]);
            end
        end
        n_checks++;
        if (overlap !== 0 || psel_rise !== 4 || psel_cyc !== 8) begin
            n_errors++;
            $display("FAIL b2b_bursts: overlap=%0d bursts=%0d psel_cycles=%0d required 0 4 8",
                     overlap, psel_rise, psel_cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_watchdog: time=%0t required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_slverr();
        test_rsp_hold();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
